// File: rtl/deserializer.sv
// Serial-to-parallel converter: collects N bits under a valid/ready handshake
// and presents each completed word on a registered valid/ready output port.
module deserializer #(
    parameter int N         = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic         recv_msg,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [N-1:0] send_msg
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [N-1:0]  r_sr;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_oq;
    logic          r_full;

    logic [N-1:0]  w_sr_shift;
    logic [N-1:0]  w_sr_next;
    logic [CW-1:0] w_cnt_next;
    logic [N-1:0]  w_oq_next;
    logic          w_full_next;
    logic          w_recv_fire;
    logic          w_send_fire;
    logic          w_slot_free;

    // Bit order is fixed at elaboration: shift toward bit 0 or toward bit N-1.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sr_shift = {r_sr[N-2:0], recv_msg};
        end else begin : g_lsb_first
            assign w_sr_shift = {recv_msg, r_sr[N-1:1]};
        end
    endgenerate

    assign recv_rdy    = (r_cnt != CNT_FULL);
    assign send_val    = r_full;
    assign send_msg    = r_oq;
    assign w_recv_fire = recv_val && recv_rdy;
    assign w_send_fire = r_full && send_rdy;
    assign w_slot_free = !r_full || w_send_fire;

    always_comb begin
        w_sr_next   = r_sr;
        w_cnt_next  = r_cnt;
        w_oq_next   = r_oq;
        w_full_next = r_full;

        if (w_send_fire) begin
            w_full_next = 1'b0;
        end

        if (r_cnt == CNT_FULL) begin
            // A completed word is parked in SR until the output slot frees up.
            if (w_slot_free) begin
                w_oq_next   = r_sr;
                w_full_next = 1'b1;
                w_cnt_next  = '0;
            end
        end else if (w_recv_fire) begin
            w_sr_next = w_sr_shift;
            if (r_cnt == CNT_LAST) begin
                if (w_slot_free) begin
                    w_oq_next   = w_sr_shift;
                    w_full_next = 1'b1;
                    w_cnt_next  = '0;
                end else begin
                    w_cnt_next  = CNT_FULL;
                end
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_oq   <= '0;
            r_full <= 1'b0;
        end else begin
            r_sr   <= w_sr_next;
            r_cnt  <= w_cnt_next;
            r_oq   <= w_oq_next;
            r_full <= w_full_next;
        end
    end

endmodule
